// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter in front of a UART transmitter: one FIFO per requester,
// round-robin selection, and one frame in flight at a time.
module uart_tx_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx_write,
    output logic [7:0] tx_data,
    input  logic       tx_finished,
    output logic       busy,
    output logic       grant
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e        state_q;
    logic          tx_write_q;
    logic [7:0]    tx_data_q;
    logic          grant_q;
    logic          busy_q;

    logic [1:0]    valid;
    logic [1:0]    ready_q;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    empty;
    logic [1:0]    full_d;
    logic [7:0]    wdata    [2];
    logic [7:0]    mem_q    [2][DEPTH];
    logic [PW-1:0] wr_ptr_q [2];
    logic [PW-1:0] rd_ptr_q [2];
    logic [PW-1:0] wr_ptr_d [2];
    logic [PW-1:0] rd_ptr_d [2];

    logic          any_pending;
    logic          sel;
    logic [7:0]    head;

    assign valid    = {req1_valid, req0_valid};
    assign wdata[0] = req0_data;
    assign wdata[1] = req1_data;

    // Ready may still be high on the first reset edge; never let that become a push.
    assign push = valid & ready_q & {2{n_reset}};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
        end
    end

    assign any_pending = ~&empty;
    // Both pending: alternate away from the last grant; otherwise take the non-empty one.
    assign sel  = (~empty[0] & ~empty[1]) ? ~grant_q : empty[0];
    assign head = mem_q[sel][rd_ptr_q[sel][AW-1:0]];
    assign pop  = (state_q == StIdle && any_pending && n_reset) ? (sel ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
            full_d[i]   = (wr_ptr_d[i][AW] != rd_ptr_d[i][AW]) &&
                          (wr_ptr_d[i][AW-1:0] == rd_ptr_d[i][AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                ready_q[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                ready_q[i]  <= ~full_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i][AW-1:0]] <= wdata[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q    <= StIdle;
            tx_write_q <= 1'b0;
            tx_data_q  <= 8'h00;
            grant_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_pending) begin
                        tx_data_q  <= head;
                        grant_q    <= sel;
                        tx_write_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= StBusy;
                    end
                end
                StBusy: begin
                    tx_write_q <= 1'b0;
                    if (tx_finished) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    assign req0_ready = ready_q[0];
    assign req1_ready = ready_q[1];
    assign tx_write   = tx_write_q;
    assign tx_data    = tx_data_q;
    assign busy       = busy_q;
    assign grant      = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios with random bytes plus a random soak,
// every cycle compared against a queue-based model of the arbiter's behaviour.
module tb_uart_tx_arbiter;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_ready;
    logic       tx_write;
    logic [7:0] tx_data;
    logic       tx_finished = 1'b0;
    logic       busy;
    logic       grant;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    logic [7:0] q0[$], q1[$];
    logic [7:0] pushed0[$], pushed1[$];
    logic [7:0] cap0[$], cap1[$];
    bit         m_busy, m_write, m_grant;
    logic [7:0] m_data;
    bit [1:0]   m_ready;
    int         m_age;
    int         dacc[2];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .tx_write   (tx_write),
        .tx_data    (tx_data),
        .tx_finished(tx_finished),
        .busy       (busy),
        .grant      (grant)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        bit p0, p1;
        if (!n_reset) begin
            q0.delete(); q1.delete(); pushed0.delete(); pushed1.delete();
            m_busy = 0; m_write = 0; m_data = 8'h00; m_grant = 1; m_ready = 2'b00; m_age = 0;
            return;
        end
        p0 = req0_valid && m_ready[0];
        p1 = req1_valid && m_ready[1];
        m_write = 0;
        if (m_busy) begin
            if (tx_finished) m_busy = 0;
        end else if (q0.size() > 0 || q1.size() > 0) begin
            if (q0.size() > 0 && q1.size() > 0) m_grant = ~m_grant;
            else m_grant = (q0.size() == 0);
            m_data  = m_grant ? q1.pop_front() : q0.pop_front();
            m_write = 1;
            m_busy  = 1;
        end
        if (p0) begin q0.push_back(req0_data); pushed0.push_back(req0_data); end
        if (p1) begin q1.push_back(req1_data); pushed1.push_back(req1_data); end
        m_ready[0] = (q0.size() < DEPTH);
        m_ready[1] = (q1.size() < DEPTH);
        m_age = m_busy ? m_age + 1 : 0;
    endtask

    task automatic tick();
        if (req0_valid && req0_ready) dacc[0]++;
        if (req1_valid && req1_ready) dacc[1]++;
        model_edge();
        @(posedge clk);
        #1;
        chk("ready0", {7'd0, req0_ready}, {7'd0, m_ready[0]});
        chk("ready1", {7'd0, req1_ready}, {7'd0, m_ready[1]});
        chk("tx_write", {7'd0, tx_write}, {7'd0, m_write});
        chk("busy", {7'd0, busy}, {7'd0, m_busy});
        chk("grant", {7'd0, grant}, {7'd0, m_grant});
        chk("tx_data", tx_data, m_data);
        if (!n_reset) begin
            cap0.delete(); cap1.delete();
        end else if (tx_write) begin
            if (grant) cap1.push_back(tx_data);
            else cap0.push_back(tx_data);
        end
    endtask

    task automatic drive(input int who, input bit v, input logic [7:0] d);
        if (who == 0) begin req0_valid = v; req0_data = d; end
        else begin req1_valid = v; req1_data = d; end
    endtask

    task automatic apply_reset();
        req0_valid = 0; req1_valid = 0; tx_finished = 0;
        n_reset = 0;
        tick();
        tick();
        n_reset = 1;
        tick();
    endtask

    // Let the UART finish every frame, then compare each requester's stream end to end.
    task automatic drain(input int max_cyc);
        int n = 0;
        req0_valid = 0; req1_valid = 0;
        while ((m_busy || q0.size() != 0 || q1.size() != 0) && n < max_cyc) begin
            tx_finished = m_busy && (m_age >= 2);
            tick();
            n++;
        end
        tx_finished = 0;
        chk("drain_timeout", 8'(n == max_cyc), 8'd0);
        chk("stream0_len", 8'(cap0.size()), 8'(pushed0.size()));
        chk("stream1_len", 8'(cap1.size()), 8'(pushed1.size()));
        for (int i = 0; i < cap0.size() && i < pushed0.size(); i++) chk("stream0", cap0[i], pushed0[i]);
        for (int i = 0; i < cap1.size() && i < pushed1.size(); i++) chk("stream1", cap1[i], pushed1[i]);
        cap0.delete(); cap1.delete(); pushed0.delete(); pushed1.delete();
    endtask

    // Fill one FIFO while the other requester's frame stalls the UART.
    task automatic fill_test(input int who);
        int base;
        int other = 1 - who;
        apply_reset();
        drive(other, 1, 8'($urandom));
        tick();
        drive(other, 0, 8'h00);
        tick();
        base = dacc[who];
        drive(who, 1, 8'($urandom));
        for (int k = 0; k < 8; k++) begin
            int pre = dacc[who];
            tick();
            if (dacc[who] != pre) drive(who, 1, 8'($urandom));
        end
        if (who == 0) begin
            chk("full_accept0", 8'(dacc[0] - base), 8'(DEPTH));
            chk("full_ready0", {7'd0, req0_ready}, 8'd0);
        end else begin
            chk("full_accept1", 8'(dacc[1] - base), 8'(DEPTH));
            chk("full_ready1", {7'd0, req1_ready}, 8'd0);
        end
        tx_finished = 1;
        tick();
        tx_finished = 0;
        base = dacc[who];
        tick();
        chk("full_pop_no_push", 8'(dacc[who] - base), 8'd0);
        tick();
        chk("full_push_after_pop", 8'(dacc[who] - base), 8'd1);
        drain(200);
    endtask

    initial begin
        logic [7:0] b;
        int left0, left1;
        bit a0, a1;

        // Reset state.
        n_reset = 0;
        tick();
        tick();
        chk("rst_ready0", {7'd0, req0_ready}, 8'd0);
        chk("rst_grant", {7'd0, grant}, 8'd1);
        chk("rst_tx_data", tx_data, 8'h00);
        n_reset = 1;
        tick();
        chk("rel_ready0", {7'd0, req0_ready}, 8'd1);
        chk("rel_ready1", {7'd0, req1_ready}, 8'd1);

        // Single byte and two-edge latency.
        drive(0, 1, 8'h55);
        tick();
        chk("single_early", {7'd0, tx_write}, 8'd0);
        drive(0, 0, 8'h00);
        tick();
        chk("single_write", {7'd0, tx_write}, 8'd1);
        chk("single_data", tx_data, 8'h55);
        chk("single_grant", {7'd0, grant}, 8'd0);
        for (int k = 0; k < 3; k++) tick();
        chk("single_busy_hold", {7'd0, busy}, 8'd1);
        chk("single_write_once", {7'd0, tx_write}, 8'd0);
        tx_finished = 1;
        tick();
        tx_finished = 0;
        chk("single_done", {7'd0, busy}, 8'd0);
        drain(50);

        // Fairness from a fresh reset: A0,B0,A1,B1.
        apply_reset();
        drive(0, 1, 8'hA0); drive(1, 1, 8'hB0);
        tick();
        drive(0, 1, 8'hA1); drive(1, 1, 8'hB1);
        tick();
        chk("fair_first", tx_data, 8'hA0);
        drive(0, 0, 8'h00); drive(1, 0, 8'h00);
        begin
            logic [7:0] order[$];
            int n = 0;
            order.push_back(tx_data);
            while (order.size() < 4 && n < 100) begin
                tx_finished = m_busy && (m_age >= 2);
                tick();
                if (tx_write) order.push_back(tx_data);
                n++;
            end
            tx_finished = 0;
            chk("fair_count", 8'(order.size()), 8'd4);
            if (order.size() == 4) begin
                chk("fair_1", order[1], 8'hB0);
                chk("fair_2", order[2], 8'hA1);
                chk("fair_3", order[3], 8'hB1);
            end
        end
        drain(100);

        // Full FIFO on each side, including push refused on the pop edge.
        fill_test(1);
        fill_test(0);

        // Reset mid-frame with three bytes queued.
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 8'($urandom));
            tick();
        end
        drive(0, 0, 8'h00);
        chk("mid_busy", {7'd0, busy}, 8'd1);
        n_reset = 0;
        tick();
        chk("mid_rst_busy", {7'd0, busy}, 8'd0);
        chk("mid_rst_write", {7'd0, tx_write}, 8'd0);
        n_reset = 1;
        tick();
        chk("mid_ready0", {7'd0, req0_ready}, 8'd1);
        chk("mid_ready1", {7'd0, req1_ready}, 8'd1);
        b = 8'($urandom);
        drive(1, 1, b);
        tick();
        drive(1, 0, 8'h00);
        tick();
        chk("mid_next_write", {7'd0, tx_write}, 8'd1);
        chk("mid_next_grant", {7'd0, grant}, 8'd1);
        chk("mid_next_data", tx_data, b);
        drain(50);

        // Pointer wrap: 3*DEPTH bytes per requester, spurious tx_finished included.
        apply_reset();
        left0 = 3 * DEPTH;
        left1 = 3 * DEPTH;
        drive(0, 1, 8'($urandom));
        drive(1, 1, 8'($urandom));
        for (int c = 0; c < 2000 && (left0 > 0 || left1 > 0); c++) begin
            tx_finished = ($urandom_range(0, 2) == 0);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            tick();
            if (a0) begin left0--; req0_data = 8'($urandom); end
            if (a1) begin left1--; req1_data = 8'($urandom); end
            req0_valid = (left0 > 0) && ($urandom_range(0, 3) != 0);
            req1_valid = (left1 > 0) && ($urandom_range(0, 3) != 0);
        end
        chk("wrap_left0", 8'(left0), 8'd0);
        chk("wrap_left1", 8'(left1), 8'd0);
        drain(200);

        // Random soak.
        for (int c = 0; c < 1500; c++) begin
            req0_valid  = $urandom_range(0, 1) == 1;
            req1_valid  = $urandom_range(0, 1) == 1;
            req0_data   = 8'($urandom);
            req1_data   = 8'($urandom);
            tx_finished = $urandom_range(0, 3) == 0;
            tick();
        end
        drain(400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter DEPTH, default 4, giving per-requester FIFO entries; legal values are powers of two from 2 to 16.

Ports:
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port n_reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port req0_valid, input, 1 bit: requester 0 offers a byte.
REQ-005 The block SHALL have port req0_data, input, 8 bits: requester 0 byte.
REQ-006 The block SHALL have port req0_ready, output, 1 bit: FIFO 0 not full.
REQ-007 The block SHALL have ports req1_valid, req1_data and req1_ready, identical to REQ-004 to REQ-006, for requester 1.
REQ-008 The block SHALL have port tx_write, output, 1 bit: start pulse to the UART transmitter.
REQ-009 The block SHALL have port tx_data, output, 8 bits: byte presented to the UART transmitter.
REQ-010 The block SHALL have port tx_finished, input, 1 bit: one-cycle end-of-frame pulse from the UART.
REQ-011 The block SHALL have port busy, output, 1 bit: a frame is in flight.
REQ-012 The block SHALL have port grant, output, 1 bit: index of the requester owning the current or last frame.

Function
REQ-013 Each requester SHALL own one FIFO of DEPTH entries, with pointers of width $clog2(DEPTH)+1 that wrap modulo 2*DEPTH.
REQ-014 reqN_ready SHALL be the registered not-full flag of FIFO N; a push occurs exactly when reqN_valid && reqN_ready at a rising edge.
REQ-015 A push on a full FIFO SHALL NOT occur; data is retained by the requester and no FIFO state changes.
REQ-016 When a pop of FIFO N occurs at an edge where FIFO N is full, a simultaneous push to FIFO N SHALL be refused, because ready was low that cycle.
REQ-017 When push and pop of the same non-full, non-empty FIFO occur at the same edge, both SHALL take effect and the count SHALL be unchanged.
REQ-018 The FSM SHALL have two states:
- IDLE: waiting to select a FIFO.
- BUSY: a frame is in flight; leave only on tx_finished.
REQ-019 In IDLE with at least one FIFO non-empty, at the next edge the FSM SHALL:
- pop the selected FIFO's head into tx_data;
- set grant to the selected index;
- drive tx_write to 1;
- enter BUSY.
REQ-020 Selection SHALL be round-robin: if both FIFOs are non-empty, pick the index other than the last granted; if only one is non-empty, pick it.
REQ-021 tx_write SHALL be high for exactly one cycle per frame and SHALL never be high in BUSY after that first cycle.
REQ-022 tx_data and grant SHALL be held stable from the tx_write cycle until the FSM returns to IDLE.
REQ-023 In BUSY, tx_finished=1 SHALL return the FSM to IDLE at that edge; the next selection can occur at the following edge, giving at least one IDLE cycle between frames.
REQ-024 tx_finished while in IDLE SHALL be ignored.
REQ-025 busy SHALL be 1 exactly when the FSM is in BUSY.
REQ-026 Latency: a byte pushed at edge E into an empty system SHALL produce tx_write=1 in the cycle following edge E+1.
REQ-027 Bytes from one requester SHALL be transmitted in push order; no byte is ever dropped or duplicated.

Reset
REQ-028 With n_reset=0 at an edge, the block SHALL enter the following state regardless of state, including mid-frame:
- FSM=IDLE;
- both FIFOs empty, pointers 0;
- tx_write=0, tx_data=0, busy=0;
- grant=1, so that requester 0 wins the first tie;
- req0_ready=req1_ready=1 from the first edge after n_reset rises.
REQ-029 During reset no push or pop SHALL occur; the UART shares n_reset, so no stale tx_finished is expected after reset.

Verification
REQ-030 Single byte: push 0x55 on req0 into an empty system -> tx_write one cycle later with tx_data=0x55, grant=0, busy=1 until tx_finished.
REQ-031 Fairness: preload req0 with A0,A1 and req1 with B0,B1 at the same edges -> transmit order A0,B0,A1,B1.
REQ-032 Full: DEPTH=4, UART stalled (no tx_finished) -> req1 accepts exactly 4 bytes, req1_ready=0 thereafter; one pop later, ready returns to 1 and a new byte is accepted.
REQ-033 Full with simultaneous valid and pop: req0 full, valid held, pop at edge E -> no push at E; push at E+1.
REQ-034 Reset mid-frame: assert n_reset while busy=1 with 3 bytes queued -> busy=0, tx_write=0, both FIFOs empty, readies=1; the next pushed byte from req1 alone is sent with grant=1.
REQ-035 Spurious tx_finished pulses in IDLE -> no state change; pointer wrap is checked over 3*DEPTH bytes per requester with data intact.
